// File: rtl/nes_input_pkg.sv
// Shared types and constants for the NES board-input conditioning logic.
package nes_input_pkg;

    typedef enum logic [1:0] {
        LEVEL  = 2'b00,
        PULSE  = 2'b01,
        TOGGLE = 2'b10,
        REPEAT = 2'b11
    } key_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DELAY = 2'b01,
        RPT   = 2'b10
    } rpt_state_e;

    // 20 ms of stability at the 50 MHz board clock
    localparam int KEY_DEBOUNCE_20MS_50MHZ = 1_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, active-level normaliser, debouncer,
// press/release/toggle events and an auto-repeat FSM whose state is exposed for debug.
module key_debounce_ch
    import nes_input_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_20MS_50MHZ,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_raw,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_toggle,
    output logic       key_repeat,
    output rpt_state_e rpt_state
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic             RELEASED_RAW = (ACTIVE_LOW != 0);

    logic [1:0]       sync_q;
    logic             pressed;
    logic [DB_W-1:0]  db_cnt_q;
    logic             accept;
    logic             press_d;
    logic             release_d;

    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_pulse_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {2{RELEASED_RAW}};
        else       sync_q <= {sync_q[0], key_raw};
    end

    assign pressed   = RELEASED_RAW ? ~sync_q[1] : sync_q[1];
    assign accept    = (pressed != key_level) && (db_cnt_q == DB_LAST);
    assign press_d   = accept && pressed;
    assign release_d = accept && !pressed;

    // Any sample agreeing with the accepted level restarts the stability count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_toggle  <= 1'b0;
        end else begin
            if (pressed == key_level || accept) db_cnt_q <= '0;
            else                                db_cnt_q <= db_cnt_q + DB_W'(1);
            if (accept) key_level <= pressed;
            key_press   <= press_d;
            key_release <= release_d;
            if (press_d) key_toggle <= ~key_toggle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rpt_cnt_q  <= '0;
            key_repeat <= 1'b0;
        end else begin
            state_q    <= state_d;
            rpt_cnt_q  <= rpt_cnt_d;
            key_repeat <= rpt_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_d) begin
                    state_d     = DELAY;
                    rpt_cnt_d   = '0;
                    rpt_pulse_d = 1'b1;
                end
            end
            DELAY: begin
                if (release_d) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == DELAY_LAST) begin
                    state_d     = RPT;
                    rpt_cnt_d   = '0;
                    rpt_pulse_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
            RPT: begin
                if (release_d) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == PERIOD_LAST) begin
                    rpt_cnt_d   = '0;
                    rpt_pulse_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    assign rpt_state = state_q;

endmodule

// File: rtl/nes_key_conditioner.sv
// Conditions the board KEY bank: one key_debounce_ch per key plus a per-key
// key_out view selected at elaboration time by KEY_MODE.
module nes_key_conditioner
    import nes_input_pkg::*;
#(
    parameter int                  NUM_KEYS        = 4,
    parameter int                  ACTIVE_LOW      = 1,
    parameter int                  DEBOUNCE_CYCLES = KEY_DEBOUNCE_20MS_50MHZ,
    parameter int                  REPEAT_DELAY    = 25_000_000,
    parameter int                  REPEAT_PERIOD   = 5_000_000,
    parameter logic [2*NUM_KEYS-1:0] KEY_MODE      = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_KEYS-1:0]   key_in,
    output logic [NUM_KEYS-1:0]   key_level,
    output logic [NUM_KEYS-1:0]   key_press,
    output logic [NUM_KEYS-1:0]   key_release,
    output logic [NUM_KEYS-1:0]   key_toggle,
    output logic [NUM_KEYS-1:0]   key_repeat,
    output logic [NUM_KEYS-1:0]   key_out,
    output logic [2*NUM_KEYS-1:0] key_rpt_state
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        localparam key_mode_e MODE = key_mode_e'(KEY_MODE[2*i +: 2]);
        rpt_state_e st;

        key_debounce_ch #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .key_raw     (key_in[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_toggle  (key_toggle[i]),
            .key_repeat  (key_repeat[i]),
            .rpt_state   (st)
        );

        assign key_rpt_state[2*i +: 2] = st;

        // Outputs are already registered, so the view adds no latency.
        assign key_out[i] = (MODE == PULSE)  ? key_press[i]  :
                            (MODE == TOGGLE) ? key_toggle[i] :
                            (MODE == REPEAT) ? key_repeat[i] :
                                               key_level[i];
    end

endmodule

// File: tb/tb_nes_key_conditioner.sv
// Directed and randomized checks of nes_key_conditioner against a sample-history
// reference model with arithmetic repeat timing.
module tb_nes_key_conditioner;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level, key_press, key_release, key_toggle, key_repeat, key_out;
    logic [2*NK-1:0] rpt_dbg;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_hist [NK];
    logic        m_level [NK];
    logic        m_press [NK];
    logic        m_rel [NK];
    logic        m_tog [NK];
    logic        m_rpt [NK];
    int          m_pedge [NK];
    int          m_edge;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    nes_key_conditioner #(
        .NUM_KEYS        (NK),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .KEY_MODE        (8'b11_10_01_00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_in        (key_in),
        .key_level     (key_level),
        .key_press     (key_press),
        .key_release   (key_release),
        .key_toggle    (key_toggle),
        .key_repeat    (key_repeat),
        .key_out       (key_out),
        .key_rpt_state (rpt_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_hist[k]  = '0;
            m_level[k] = 1'b0;
            m_press[k] = 1'b0;
            m_rel[k]   = 1'b0;
            m_tog[k]   = 1'b0;
            m_rpt[k]   = 1'b0;
            m_pedge[k] = 0;
        end
    endtask

    // A change is accepted once the last DB synchronised samples (2 edges old) all differ.
    task automatic model_edge();
        m_edge++;
        for (int k = 0; k < NK; k++) begin
            logic all_diff;
            int   d;
            m_hist[k] = {m_hist[k][14:0], ~key_in[k]};
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++)
                if (m_hist[k][2+j] == m_level[k]) all_diff = 1'b0;
            m_press[k] = all_diff && !m_level[k];
            m_rel[k]   = all_diff && m_level[k];
            if (m_press[k]) begin
                m_rpt[k]   = 1'b1;
                m_pedge[k] = m_edge;
            end else if (m_level[k] && !m_rel[k]) begin
                d = m_edge - m_pedge[k];
                m_rpt[k] = (d >= RD) && ((d - RD) % RP == 0);
            end else begin
                m_rpt[k] = 1'b0;
            end
            if (all_diff) m_level[k] = ~m_level[k];
            if (m_press[k]) m_tog[k] = ~m_tog[k];
        end
    endtask

    task automatic check_all();
        logic [NK-1:0] lv, pr, rl, tg, rp, ko;
        for (int k = 0; k < NK; k++) begin
            lv[k] = m_level[k];
            pr[k] = m_press[k];
            rl[k] = m_rel[k];
            tg[k] = m_tog[k];
            rp[k] = m_rpt[k];
        end
        ko = {rp[3], tg[2], pr[1], lv[0]};
        chk("level",   32'(key_level),   32'(lv));
        chk("press",   32'(key_press),   32'(pr));
        chk("release", 32'(key_release), 32'(rl));
        chk("toggle",  32'(key_toggle),  32'(tg));
        chk("repeat",  32'(key_repeat),  32'(rp));
        chk("key_out", 32'(key_out),     32'(ko));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        if (!reset) check_all();
        else begin
            chk("in_reset_level", 32'(key_level), 32'd0);
            chk("in_reset_out",   32'(key_out),   32'd0);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        ticks(n);
        reset = 1'b0;
    endtask

    initial begin
        logic seen;
        m_edge = 0;
        key_in = 4'hF;
        reset  = 1'b1;
        model_reset();
        @(negedge clk);

        // 1. reset state, then first press of key 0
        ticks(3);
        chk("reset_outputs", 32'({key_level, key_press, key_release, key_toggle, key_repeat}), 32'd0);
        reset = 1'b0;
        ticks(2);
        key_in[0] = 1'b0;
        ticks(5);
        chk("t1_level_before", 32'(key_level[0]), 32'd0);
        tick();
        chk("t1_level_edge6", 32'(key_level[0]), 32'd1);
        chk("t1_press_edge6", 32'(key_press[0]), 32'd1);
        tick();
        chk("t1_press_once", 32'(key_press[0]), 32'd0);
        chk("t1_toggle", 32'(key_toggle[0]), 32'd1);

        // 2. bounce on key 1 is rejected
        seen = 1'b0;
        key_in[1] = 1'b0; for (int i = 0; i < 3; i++) begin tick(); seen |= key_press[1] | key_level[1]; end
        key_in[1] = 1'b1; for (int i = 0; i < 2; i++) begin tick(); seen |= key_press[1] | key_level[1]; end
        key_in[1] = 1'b0; for (int i = 0; i < 3; i++) begin tick(); seen |= key_press[1] | key_level[1]; end
        key_in[1] = 1'b1; for (int i = 0; i < 8; i++) begin tick(); seen |= key_press[1] | key_level[1]; end
        chk("t2_bounce_rejected", 32'(seen), 32'd0);

        // 3. release of key 0, then a second press clears the toggle
        key_in[0] = 1'b1;
        ticks(5);
        chk("t3_release_before", 32'(key_release[0]), 32'd0);
        tick();
        chk("t3_release_edge6", 32'(key_release[0]), 32'd1);
        chk("t3_toggle_kept", 32'(key_toggle[0]), 32'd1);
        tick();
        chk("t3_release_once", 32'(key_release[0]), 32'd0);
        key_in[0] = 1'b0;
        ticks(7);
        chk("t3_toggle_second", 32'(key_toggle[0]), 32'd0);
        key_in[0] = 1'b1;
        ticks(8);

        // 4. auto-repeat timing on key 2
        exp_q = {};
        got_q = {};
        exp_q.push_back(32'd6);
        for (int t = 6 + RD; t <= 40; t += RP) exp_q.push_back(32'(t));
        key_in[2] = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (key_repeat[2]) got_q.push_back(32'(t));
        end
        chk("t4_pulse_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("t4_pulse_edge", got_q[i], exp_q[i]);
        key_in[2] = 1'b1;
        ticks(6);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); seen |= key_repeat[2]; end
        chk("t4_repeat_stopped", 32'(seen), 32'd0);

        // 5. simultaneous press of all keys, mixed key_out views
        key_in = 4'h0;
        ticks(6);
        chk("t5_press_all", 32'(key_press), 32'hF);
        chk("t5_key_out", 32'(key_out), 32'hB);
        ticks(3);

        // 6. reset while held, fresh press afterwards
        chk("t6_level_held", 32'(key_level[3]), 32'd1);
        pulse_reset(2);
        chk("t6_async_zero", 32'({key_level, key_toggle}), 32'd0);
        ticks(5);
        chk("t6_press_before", 32'(key_press[3]), 32'd0);
        tick();
        chk("t6_press_after", 32'(key_press), 32'hF);
        key_in = 4'hF;
        ticks(10);

        // randomized segments with occasional mid-run reset
        for (int s = 0; s < 80; s++) begin
            key_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) pulse_reset($urandom_range(1, 3));
            ticks($urandom_range(1, 9));
        end
        key_in = 4'hF;
        ticks(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
